// File: rtl/uart_pkg.sv
// Shared constants, state encoding and divider clamp for the buffered UART transmitter.
package uart_pkg;
   localparam int FRAME_BITS = 10;
   localparam int MIN_DIV    = 2;

   typedef enum logic {IDLE, SHIFT} tx_state_e;

   function automatic logic [31:0] eff_div(input logic [31:0] raw);
      return (raw < 32'(MIN_DIV)) ? 32'(MIN_DIV) : raw;
   endfunction
endpackage

// File: rtl/uart_tx_fifo_if.sv
// CPU-side bus of the UART transmitter: divider register access and byte push handshake.
interface uart_tx_fifo_if;
   logic [3:0]  cfg_div_we;
   logic [31:0] cfg_div_di;
   logic [31:0] cfg_div_do;
   logic        dat_we;
   logic [7:0]  dat_di;
   logic        dat_wait;

   modport master (output cfg_div_we, cfg_div_di, dat_we, dat_di,
                   input  cfg_div_do, dat_wait);
   modport slave  (input  cfg_div_we, cfg_div_di, dat_we, dat_di,
                   output cfg_div_do, dat_wait);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with one extra pointer bit so full and empty are told apart without a counter.
module sync_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             full_q, full_d;
   logic             empty_q, empty_d;
   logic             do_push, do_pop;

   always_comb begin
      do_push  = push && !full_q;
      do_pop   = pop && !empty_q;
      wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
      rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
      empty_d  = (wr_ptr_d == rd_ptr_d);
      full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
   end

   assign dout  = mem_q[rd_ptr_q[AW-1:0]];
   assign full  = full_q;
   assign empty = empty_q;
   assign level = wr_ptr_q - rd_ptr_q;
endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 transmitter: divider register, per-bit cycle timer and the frame shifter FSM.
//   state | meaning
//   IDLE  | line high, waiting for a queued byte
//   SHIFT | frame in flight, ser_tx follows shift_q[0] one clock later
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH       = 16,
   parameter int DEFAULT_DIV = 106
) (
   input  logic                   clk,
   input  logic                   reset,
   uart_tx_fifo_if.slave          bus,
   output logic                   ser_tx,
   output logic                   tx_busy,
   output logic [$clog2(DEPTH):0] fifo_level
);
   tx_state_e   state_q, state_d;
   logic [31:0] div_q, div_d;
   logic [31:0] div_act_q, div_act_d;
   logic [31:0] cyc_q, cyc_d;
   logic [3:0]  bit_cnt_q, bit_cnt_d;
   logic [9:0]  shift_q, shift_d;
   logic        ser_tx_q, ser_tx_d;
   logic        load;
   logic        fifo_empty, fifo_full;
   logic [7:0]  fifo_dout;

   sync_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (bus.dat_we),
      .din   (bus.dat_di),
      .pop   (load),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   always_comb begin
      div_d = div_q;
      for (int i = 0; i < 4; i++) begin
         if (bus.cfg_div_we[i]) div_d[8*i +: 8] = bus.cfg_div_di[8*i +: 8];
      end
   end

   always_comb begin
      state_d   = state_q;
      div_act_d = div_act_q;
      cyc_d     = cyc_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      load      = 1'b0;
      ser_tx_d  = (state_q == SHIFT) ? shift_q[0] : 1'b1;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) load = 1'b1;
         end
         SHIFT: begin
            if (cyc_q == div_act_q - 32'd1) begin
               cyc_d     = '0;
               shift_d   = {1'b1, shift_q[9:1]};
               bit_cnt_d = bit_cnt_q + 4'd1;
               if (bit_cnt_q == 4'(FRAME_BITS - 1)) begin
                  // chain the next frame straight after the stop bit
                  if (!fifo_empty) load = 1'b1;
                  else             state_d = IDLE;
               end
            end else begin
               cyc_d = cyc_q + 32'd1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (load) begin
         shift_d   = {1'b1, fifo_dout, 1'b0};
         div_act_d = eff_div(div_q);
         bit_cnt_d = '0;
         cyc_d     = '0;
         state_d   = SHIFT;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         div_q     <= 32'(DEFAULT_DIV);
         div_act_q <= eff_div(32'(DEFAULT_DIV));
         cyc_q     <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '1;
         ser_tx_q  <= 1'b1;
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         div_act_q <= div_act_d;
         cyc_q     <= cyc_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         ser_tx_q  <= ser_tx_d;
      end
   end

   assign ser_tx         = ser_tx_q;
   assign tx_busy        = (state_q != IDLE) || !fifo_empty;
   assign bus.dat_wait   = bus.dat_we && fifo_full;
   assign bus.cfg_div_do = div_q;
endmodule
